// File: rtl/cnn_layer_accel_row_fetch_ctrl.sv
// rtl/cnn_layer_accel_row_fetch_ctrl.sv - write-side row fetch sequencer for a CNN prefetch buffer
// Optional statistics outputs (stall_cycles, cncl_rows) are enabled by defining CNN_ROW_FETCH_STATS_EN.
module cnn_layer_accel_row_fetch_ctrl #(
  parameter int C_PIXEL_WIDTH  = 16,
  parameter int C_MAX_NUM_COLS = 512,
  parameter int C_CW           = $clog2(C_MAX_NUM_COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_start,
  input  logic [C_CW-1:0]          num_cols,
  input  logic [C_CW-1:0]          num_rows,
  input  logic                     job_abort,
  input  logic                     cncl_fetch_req,
  output logic                     fetch_req,
  output logic [C_CW-1:0]          fetch_row,
  input  logic                     fetch_ack,
  input  logic                     pix_valid,
  input  logic [C_PIXEL_WIDTH-1:0] pix_data,
  output logic                     pix_ready,
  output logic                     pfb_wr_en,
  output logic [C_PIXEL_WIDTH-1:0] pfb_din,
  input  logic                     pfb_row_consumed,
  output logic                     job_fetch_ack,
  output logic                     row_done,
  output logic                     job_done,
  input  logic                     job_complete_ack,
`ifdef CNN_ROW_FETCH_STATS_EN
  output logic [31:0]              stall_cycles,
  output logic [C_CW-1:0]          cncl_rows,
`endif
  output logic                     busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_XFER,
    ST_WAIT_PFB,
    ST_DONE
  } state_t;

  localparam logic [C_CW-1:0] ONE = C_CW'(1);

  state_t          state;
  logic [C_CW-1:0] row_cnt;
  logic [C_CW-1:0] col_cnt;
  logic [C_CW-1:0] num_cols_q;
  logic [C_CW-1:0] num_rows_q;
  logic            beat;

  // Handshake-level outputs decode the state register directly so they drop
  // the cycle the state changes (abort, async reset) without an extra flop stage.
  assign fetch_req = (state == ST_REQ);
  assign fetch_row = fetch_req ? row_cnt : '0;
  assign pix_ready = (state == ST_XFER);
  assign job_done  = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign beat      = pix_ready && pix_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      row_cnt       <= '0;
      col_cnt       <= '0;
      num_cols_q    <= '0;
      num_rows_q    <= '0;
      pfb_wr_en     <= 1'b0;
      pfb_din       <= '0;
      job_fetch_ack <= 1'b0;
      row_done      <= 1'b0;
    end else begin
      job_fetch_ack <= 1'b0;
      row_done      <= 1'b0;
      pfb_wr_en     <= 1'b0;

      // An accepted pixel is always written, even in an abort cycle, since
      // upstream has already seen the handshake complete.
      if (beat) begin
        pfb_wr_en <= 1'b1;
        pfb_din   <= pix_data;
      end

      if (job_abort) begin
        state   <= ST_IDLE;
        col_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (job_start) begin
              num_cols_q    <= num_cols;
              num_rows_q    <= num_rows;
              row_cnt       <= '0;
              col_cnt       <= '0;
              job_fetch_ack <= 1'b1;
              state         <= (num_rows == '0 || num_cols == '0) ? ST_DONE : ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (cncl_fetch_req) begin
              row_done <= 1'b1;
              state    <= ST_WAIT_PFB;
            end else begin
              state <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (fetch_ack) state <= ST_XFER;
          end
          ST_XFER: begin
            if (pix_valid) begin
              if (col_cnt == num_cols_q - ONE) begin
                row_done <= 1'b1;
                col_cnt  <= '0;
                state    <= ST_WAIT_PFB;
              end else begin
                col_cnt <= col_cnt + ONE;
              end
            end
          end
          ST_WAIT_PFB: begin
            if (pfb_row_consumed) begin
              if (row_cnt == num_rows_q - ONE) begin
                state <= ST_DONE;
              end else begin
                row_cnt <= row_cnt + ONE;
                state   <= ST_CHECK;
              end
            end
          end
          ST_DONE: begin
            if (job_complete_ack) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CNN_ROW_FETCH_STATS_EN
  logic job_accept;
  assign job_accept = (state == ST_IDLE) && job_start && !job_abort;

  // Saturating counters; they only move in XFER/CHECK so they hold through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      cncl_rows    <= '0;
    end else if (job_accept) begin
      stall_cycles <= '0;
      cncl_rows    <= '0;
    end else if (!job_abort) begin
      if (state == ST_XFER && !pix_valid && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (state == ST_CHECK && cncl_fetch_req && cncl_rows != '1)
        cncl_rows <= cncl_rows + ONE;
    end
  end
`endif

endmodule

// File: doc/cnn_layer_accel_row_fetch_ctrl.md
Name: cnn_layer_accel_row_fetch_ctrl

Overview:
- Write-side sequencer for one CNN layer accelerator prefetch buffer.
- Per job, walks input rows 0..num_rows-1.
- Per row: issues a fetch request upstream, accepts num_cols pixels over a valid/ready stream, and writes them into the prefetch buffer.
- Skips rows the buffer cancels (padding/upsample repeat rows). Paces rows against buffer consumption.

Parameters:
- C_PIXEL_WIDTH, 16, pixel/data width (matches `PIXEL_WIDTH).
- C_MAX_NUM_COLS, 512, max row length; C_CW = $clog2(C_MAX_NUM_COLS) is the width of all row/col fields.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- job_start  in  1  pulse; starts job, latches num_cols/num_rows
- num_cols  in  C_CW  pixels per row
- num_rows  in  C_CW  rows per job
- job_abort  in  1  synchronous abort pulse
- cncl_fetch_req  in  1  from prefetch buffer; row needs no fetch
- fetch_req  out  1  upstream row fetch request
- fetch_row  out  C_CW  row index for fetch_req
- fetch_ack  in  1  upstream accepts request
- pix_valid  in  1  upstream pixel valid
- pix_data  in  C_PIXEL_WIDTH  upstream pixel
- pix_ready  out  1  ready for upstream pixel
- pfb_wr_en  out  1  prefetch buffer write enable
- pfb_din  out  C_PIXEL_WIDTH  prefetch buffer write data
- pfb_row_consumed  in  1  pulse; buffer finished reading current row
- job_fetch_ack  out  1  pulse; clears buffer write address
- row_done  out  1  pulse per row (fetched or cancelled)
- job_done  out  1  level; job complete
- job_complete_ack  in  1  pulse; releases job_done
- busy  out  1  high in any state except ST_IDLE

Behaviour:
- Reset values: state ST_IDLE; all outputs 0; counters 0.
- ST_IDLE:
  - On job_start, latch num_cols/num_rows, clear row_cnt/col_cnt, and pulse job_fetch_ack for 1 cycle.
  - If num_rows==0 or num_cols==0, go to ST_DONE; else go to ST_CHECK.
  - job_start outside ST_IDLE is ignored.
- ST_CHECK (1 cycle): sample cncl_fetch_req.
  - If 1: pulse row_done, go to ST_WAIT_PFB, and write nothing.
  - Else: go to ST_REQ.
- ST_REQ:
  - fetch_req=1 and fetch_row=row_cnt, held stable until fetch_ack.
  - On fetch_ack, go to ST_XFER; fetch_req is 0 from the next cycle.
  - fetch_ack outside ST_REQ is ignored.
- ST_XFER:
  - pix_ready=(state==ST_XFER).
  - Each beat (pix_valid&&pix_ready) drives pfb_wr_en=1 and pfb_din=pix_data, registered with 1-cycle latency, and increments col_cnt.
  - On the beat with col_cnt==num_cols-1: pulse row_done (aligned with the last pfb_wr_en), clear col_cnt, go to ST_WAIT_PFB.
  - Exactly num_cols writes per fetched row.
- ST_WAIT_PFB: on pfb_row_consumed:
  - if row_cnt==num_rows-1, go to ST_DONE;
  - else row_cnt++ and go to ST_CHECK.
  - pfb_row_consumed in other states is ignored.
- ST_DONE: job_done=1 until job_complete_ack, then ST_IDLE next cycle.
- job_abort in any state:
  - go to ST_IDLE next cycle;
  - drop fetch_req and pix_ready;
  - a registered write in flight still completes;
  - no row_done/job_done is issued.
- Abort has priority over all other transitions in the same cycle.
- Asynchronous rst mid-operation: immediate return to reset values; the in-flight write is lost.
- Counters are C_CW bits, compared with equality only; num_cols==C_MAX_NUM_COLS is not representable (max is 2^C_CW-1).

Optional Feature:
- CNN_ROW_FETCH_STATS_EN. When defined, add these outputs:
  - stall_cycles (32b): cycles in ST_XFER with pix_valid==0.
  - cncl_rows (C_CW): rows skipped via cncl_fetch_req.
- Both counters saturate, clear on accepted job_start, and hold after job_done.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- num_cols=4, num_rows=2, no cancel, pix_valid always 1, pfb_row_consumed 3 cycles after each row_done:
  - expect job_fetch_ack ×1, fetch_row 0 then 1, 8 pfb_wr_en with data matching input order, row_done ×2, job_done held until job_complete_ack.
- num_rows=3 with cncl_fetch_req=1 for row 0 and row 2:
  - expect a single fetch_req (row 1), only 4 writes, row_done ×3.
  - With stats enabled, cncl_rows=2.
- fetch_ack delayed 10 cycles, pix_valid toggled every other cycle, num_cols=5:
  - fetch_req/fetch_row stable for the full 10 cycles, exactly 5 writes.
  - With stats enabled, stall_cycles=4.
- job_abort in ST_XFER after 2 of 4 beats:
  - ST_IDLE next cycle, pix_ready=0, no row_done.
  - A new job_start then fetches from row 0.
- Async rst asserted mid-ST_REQ:
  - fetch_req=0 immediately, busy=0.
  - job_start and stray pfb_row_consumed/fetch_ack pulses sent while idle cause no action except the job_start sequence.
- num_rows=0:
  - job_fetch_ack pulse, then job_done with no fetch_req.
  - job_start during the busy job is ignored.
